// File: rtl/act_pkg.sv
// Shared constants and types for the polynomial activation pipeline.
package act_pkg;

    localparam int          FRAC_I   = 16;
    localparam logic [17:0] ONE_Q16  = 18'h10000;
    localparam logic [17:0] HALF_Q16 = 18'h08000;

    typedef enum logic {
        ACT_SIGMOID = 1'b0,
        ACT_TANH    = 1'b1
    } act_mode_e;

endpackage

// File: rtl/act_cube_mult.sv
// Two registered stages: |x| in Q2.16 -> a^2 -> a^3 -> cubic polynomial p (Q1.16).
// A side-band tag (valid/sign/mode/sat) travels alongside the data and is held with it.
module act_cube_mult
    import act_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int IN_FRAC = 5,
    parameter int C3      = 1365,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [IN_W+1:0]  a_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic [17:0]      p_out,
    output logic [TAG_W-1:0] tag_out
);

    localparam logic [15:0] C3_Q = 16'(C3);

    // a is clamped to <= 2.0, so Q2.16 fits in 18 bits; a^2 <= 4.0 in 19, a^3 <= 8.0 in 20.
    logic [35:0]      a_shift;
    logic [17:0]      aq;
    logic [35:0]      sq_full;
    logic [17:0]      aq_reg;
    logic [18:0]      a2_reg;
    logic [TAG_W-1:0] tag2_reg;
    logic [36:0]      cube_full;
    logic [19:0]      a3;
    logic [35:0]      cterm_full;
    logic [20:0]      p_full;
    logic [17:0]      p_reg;
    logic [TAG_W-1:0] tag3_reg;
    logic             unused_bits;

    assign a_shift = 36'(a_in) << (FRAC_I - IN_FRAC);
    assign aq      = a_shift[17:0];
    assign sq_full = 36'(aq) * 36'(aq);

    // Square stage: realigned operand and a^2 (truncated to 16 fraction bits).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aq_reg   <= '0;
            a2_reg   <= '0;
            tag2_reg <= '0;
        end else if (en) begin
            aq_reg   <= aq;
            a2_reg   <= sq_full[34:16];
            tag2_reg <= tag_in;
        end
    end

    assign cube_full  = 37'(a2_reg) * 37'(aq_reg);
    assign a3         = cube_full[35:16];
    assign cterm_full = 36'(C3_Q) * 36'(a3);
    // 1/2 + a/4 - C3*a^3 never goes negative for a <= 2.0.
    assign p_full     = 21'(HALF_Q16) + 21'(aq_reg[17:2]) - 21'(cterm_full[35:16]);

    // Cube/polynomial stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_reg    <= '0;
            tag3_reg <= '0;
        end else if (en) begin
            p_reg    <= p_full[17:0];
            tag3_reg <= tag2_reg;
        end
    end

    assign p_out   = p_reg;
    assign tag_out = tag3_reg;

    assign unused_bits = ^{a_shift[35:18], sq_full[35], sq_full[15:0], cube_full[36],
                           cube_full[15:0], cterm_full[15:0], p_full[20:18]};

endmodule

// File: rtl/act_poly_pipe.sv
// Streaming sigmoid/tanh unit: y = 1/2 + x/4 - C3*x^3 evaluated on |x| with odd symmetry.
// Four stages (clamp, square, cube/poly, round/saturate) under one global stall.
module act_poly_pipe
    import act_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int IN_FRAC = 5,
    parameter int OUT_W   = 8,
    parameter int C3      = 1365,
    parameter int XMAX    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  x_in,
    input  logic             mode_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] y_out,
    output logic             mode_out,
    output logic             sat_out
);

    localparam logic [IN_W+1:0] XMAX_A  = (IN_W+2)'(XMAX);
    localparam int              SIG_SH  = FRAC_I - OUT_W;
    localparam int              SIG_RND = 1 << (SIG_SH - 1);
    localparam int              TNH_SH  = FRAC_I + 1 - OUT_W;
    localparam int              TNH_RND = 1 << (TNH_SH - 1);
    localparam logic [19:0]     SIG_MAX = 20'((1 << OUT_W) - 1);
    localparam logic [19:0]     TNH_MAX = 20'((1 << (OUT_W - 1)) - 1);

    logic             adv;
    logic [IN_W:0]    x_ext;
    logic [IN_W:0]    ax;
    act_mode_e        mode_s;
    logic [IN_W+1:0]  a_pre;
    logic             sat_pre;
    logic [IN_W+1:0]  a1_reg;
    logic             v1_reg;
    logic             sign1_reg;
    act_mode_e        mode1_reg;
    logic             sat1_reg;
    logic [3:0]       tag1;
    logic [3:0]       tag3;
    logic [17:0]      p3;
    logic             v3;
    logic             sign3;
    act_mode_e        mode3;
    logic             sat3;
    logic [17:0]      s_val;
    logic [19:0]      s_rnd;
    logic signed [19:0] t_s;
    logic [19:0]      t_pos;
    logic [19:0]      m_val;
    logic [OUT_W-1:0] m_out;
    logic [OUT_W-1:0] y_next;
    logic             out_valid_reg;
    logic [OUT_W-1:0] y_reg;
    act_mode_e        mode_reg;
    logic             sat_reg;

    // Whole pipe moves only when the output slot is free or being drained.
    assign adv      = !(out_valid_reg && !out_ready);
    assign in_ready = adv;

    // Magnitude in IN_W+1 bits so the most negative input is representable.
    assign x_ext   = {x_in[IN_W-1], x_in};
    assign ax      = x_in[IN_W-1] ? (~x_ext + (IN_W+1)'(1)) : x_ext;
    assign mode_s  = act_mode_e'(mode_in);
    assign a_pre   = (mode_s == ACT_TANH) ? {ax, 1'b0} : {1'b0, ax};
    assign sat_pre = a_pre > XMAX_A;

    // Stage 1: clamp |x| (doubled for tanh) and capture sign/mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_reg    <= 1'b0;
            a1_reg    <= '0;
            sign1_reg <= 1'b0;
            mode1_reg <= ACT_SIGMOID;
            sat1_reg  <= 1'b0;
        end else if (adv) begin
            v1_reg    <= in_valid;
            a1_reg    <= sat_pre ? XMAX_A : a_pre;
            sign1_reg <= x_in[IN_W-1];
            mode1_reg <= mode_s;
            sat1_reg  <= sat_pre;
        end
    end

    assign tag1 = {v1_reg, sign1_reg, mode1_reg, sat1_reg};

    act_cube_mult #(
        .IN_W    (IN_W),
        .IN_FRAC (IN_FRAC),
        .C3      (C3),
        .TAG_W   (4)
    ) u_cube (
        .clk     (clk),
        .reset   (reset),
        .en      (adv),
        .a_in    (a1_reg),
        .tag_in  (tag1),
        .p_out   (p3),
        .tag_out (tag3)
    );

    assign v3    = tag3[3];
    assign sign3 = tag3[2];
    assign mode3 = act_mode_e'(tag3[1]);
    assign sat3  = tag3[0];

    // Stage 4 logic: mirror for negative inputs, round half up, saturate.
    always_comb begin
        s_val  = sign3 ? (ONE_Q16 - p3) : p3;
        s_rnd  = (20'(s_val) + 20'(SIG_RND)) >> SIG_SH;
        t_s    = signed'(20'({p3, 1'b0})) - 20'sh10000;
        t_pos  = t_s[19] ? 20'd0 : t_s;
        m_val  = (t_pos + 20'(TNH_RND)) >> TNH_SH;
        if (m_val > TNH_MAX) begin
            m_val = TNH_MAX;
        end
        m_out  = m_val[OUT_W-1:0];
        y_next = '0;
        if (mode3 == ACT_TANH) begin
            y_next = sign3 ? (~m_out + OUT_W'(1)) : m_out;
        end else begin
            y_next = (s_rnd > SIG_MAX) ? SIG_MAX[OUT_W-1:0] : s_rnd[OUT_W-1:0];
        end
    end

    // Output register: held while downstream stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            y_reg         <= '0;
            mode_reg      <= ACT_SIGMOID;
            sat_reg       <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= v3;
            if (v3) begin
                y_reg    <= y_next;
                mode_reg <= mode3;
                sat_reg  <= sat3;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign y_out     = y_reg;
    assign mode_out  = mode_reg;
    assign sat_out   = sat_reg;

endmodule

// File: tb/tb_act_poly_pipe.sv
// Scoreboard bench for act_poly_pipe at default parameters (Q3.5 in, 8-bit out).
module tb_act_poly_pipe;

    typedef struct packed {
        logic [7:0] y;
        logic       m;
        logic       s;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x_in;
    logic       mode_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y_out;
    logic       mode_out;
    logic       sat_out;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    act_poly_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .mode_in   (mode_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .mode_out  (mode_out),
        .sat_out   (sat_out)
    );

    always #5 clk = ~clk;

    // Reference model of the polynomial activation with integer arithmetic.
    function automatic exp_t model(input logic [7:0] x, input logic md);
        longint xi, a, aq, a2, a3, p, s, t, y;
        logic   sg, st;
        exp_t   r;
        xi = longint'($signed(x));
        sg = (xi < 0);
        a  = sg ? -xi : xi;
        if (md) a = a * 2;
        st = (a > 64);
        if (st) a = 64;
        aq = a * 2048;
        a2 = (aq * aq) >> 16;
        a3 = (a2 * aq) >> 16;
        p  = 32768 + (aq >> 2) - ((1365 * a3) >> 16);
        if (!md) begin
            s = sg ? (65536 - p) : p;
            y = (s + 128) >> 8;
            if (y > 255) y = 255;
        end else begin
            t = 2 * p - 65536;
            if (t < 0) t = 0;
            y = (t + 256) >> 9;
            if (y > 127) y = 127;
            if (sg) y = (256 - y) % 256;
        end
        r.y = 8'(y);
        r.m = md;
        r.s = st;
        return r;
    endfunction

    // One clock of stimulus; entered and left at posedge+1, samples at posedge+2.
    task automatic step(input logic v, input logic [7:0] x, input logic md, input logic ordy,
                        output logic acc, output logic rdy, output logic ov, output logic fired,
                        output logic [7:0] yo, output logic mo, output logic so);
        in_valid  = v;
        x_in      = x;
        mode_in   = md;
        out_ready = ordy;
        #1;
        rdy   = in_ready;
        acc   = in_valid && in_ready;
        ov    = out_valid;
        fired = out_valid && out_ready;
        yo    = y_out;
        mo    = mode_out;
        so    = sat_out;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; x_in = '0; mode_in = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, y_out, mode_out, sat_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: got valid=%0b y=%0d mode=%0b sat=%0b expected all 0",
                     out_valid, y_out, mode_out, sat_out);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_latency();
        logic acc, rdy, ov, fired, mo, so;
        logic [7:0] yo;
        int fire_at = -1;
        sb.delete();
        for (int c = 0; c < 20 && fire_at < 0; c++) begin
            step(c == 0, 8'h00, 1'b0, 1'b1, acc, rdy, ov, fired, yo, mo, so);
            if (fired) begin
                fire_at = c;
                checks++;
                $display("[latency] x=0x00 y=%0d mode=%0b sat=%0b cycle=%0d", yo, mo, so, c);
                if ({yo, mo, so} !== {8'd128, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL latency_value: got y=%0d sat=%0b expected y=128 sat=0", yo, so);
                end
            end
        end
        checks++;
        if (fire_at != 4) begin
            errors++;
            $display("FAIL latency_cycles: got %0d expected 4", fire_at);
        end
    endtask

    task automatic test_sigmoid();
        logic [7:0] xs [6] = '{8'h00, 8'h20, 8'hE0, 8'h40, 8'h7F, 8'h80};
        logic [7:0] ys [6] = '{8'd128, 8'd187, 8'd69, 8'd213, 8'd213, 8'd43};
        logic       ss [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic acc, rdy, ov, fired, mo, so;
        logic [7:0] yo;
        exp_t e;
        int sent = 0, got = 0;
        sb.delete();
        for (int c = 0; c < 40 && got < 6; c++) begin
            step(sent < 6, (sent < 6) ? xs[sent] : 8'h00, 1'b0, 1'b1, acc, rdy, ov, fired, yo, mo, so);
            if (acc) begin
                sb.push_back(exp_t'{y: ys[sent], m: 1'b0, s: ss[sent]});
                sent++;
            end
            if (fired) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sigmoid_extra: got y=%0d expected no output", yo);
                end else begin
                    e = sb.pop_front();
                    got++;
                    $display("[sigmoid] y=%0d mode=%0b sat=%0b", yo, mo, so);
                    if ({yo, mo, so} !== {e.y, e.m, e.s}) begin
                        errors++;
                        $display("FAIL sigmoid_out: got y=%0d mode=%0b sat=%0b expected y=%0d mode=%0b sat=%0b",
                                 yo, mo, so, e.y, e.m, e.s);
                    end
                end
            end
        end
        checks++;
        if (got != 6) begin
            errors++;
            $display("FAIL sigmoid_count: got %0d expected 6", got);
        end
    endtask

    task automatic test_tanh();
        logic [7:0] xs [5] = '{8'h10, 8'hF0, 8'h00, 8'h20, 8'h21};
        logic [7:0] ys [5] = '{8'h3B, 8'hC5, 8'h00, 8'd85, 8'd85};
        logic       ss [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic acc, rdy, ov, fired, mo, so;
        logic [7:0] yo;
        exp_t e;
        int sent = 0, got = 0;
        sb.delete();
        for (int c = 0; c < 40 && got < 5; c++) begin
            step(sent < 5, (sent < 5) ? xs[sent] : 8'h00, 1'b1, 1'b1, acc, rdy, ov, fired, yo, mo, so);
            if (acc) begin
                sb.push_back(exp_t'{y: ys[sent], m: 1'b1, s: ss[sent]});
                sent++;
            end
            if (fired) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL tanh_extra: got y=%0d expected no output", yo);
                end else begin
                    e = sb.pop_front();
                    got++;
                    $display("[tanh] y=0x%02h mode=%0b sat=%0b", yo, mo, so);
                    if ({yo, mo, so} !== {e.y, e.m, e.s}) begin
                        errors++;
                        $display("FAIL tanh_out: got y=0x%02h mode=%0b sat=%0b expected y=0x%02h mode=%0b sat=%0b",
                                 yo, mo, so, e.y, e.m, e.s);
                    end
                end
            end
        end
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL tanh_count: got %0d expected 5", got);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, rdy, ov, fired, mo, so, ordy;
        logic [7:0] yo, x, held_y;
        logic held_m, held_s;
        exp_t e;
        int sent = 0, got = 0;
        sb.delete();
        held_y = '0; held_m = 1'b0; held_s = 1'b0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            ordy = !(c >= 5 && c <= 7);
            x    = 8'(sent * 37 - 100);
            step(sent < 8, x, 1'(sent % 2), ordy, acc, rdy, ov, fired, yo, mo, so);
            checks++;
            if (rdy !== ordy) begin
                errors++;
                $display("FAIL b2b_in_ready: cycle %0d got %0b expected %0b", c, rdy, ordy);
            end
            if (c == 5) begin
                held_y = yo; held_m = mo; held_s = so;
            end
            if (c == 6 || c == 7) begin
                checks++;
                if ({ov, yo, mo, so} !== {1'b1, held_y, held_m, held_s}) begin
                    errors++;
                    $display("FAIL b2b_hold: cycle %0d got valid=%0b y=%0d expected valid=1 y=%0d",
                             c, ov, yo, held_y);
                end
            end
            if (acc) begin
                sb.push_back(model(x, 1'(sent % 2)));
                sent++;
            end
            if (fired) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got y=%0d expected no output", yo);
                end else begin
                    e = sb.pop_front();
                    got++;
                    $display("[b2b] y=%0d mode=%0b sat=%0b", yo, mo, so);
                    if ({yo, mo, so} !== {e.y, e.m, e.s}) begin
                        errors++;
                        $display("FAIL b2b_out: got y=%0d mode=%0b sat=%0b expected y=%0d mode=%0b sat=%0b",
                                 yo, mo, so, e.y, e.m, e.s);
                    end
                end
            end
        end
        checks++;
        if (got != 8 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d outputs expected 8", got);
        end
    endtask

    task automatic test_random();
        logic acc, rdy, ov, fired, mo, so, md, v;
        logic [7:0] yo, x;
        exp_t e;
        int sent = 0, got = 0;
        sb.delete();
        for (int c = 0; c < 600 && got < 40; c++) begin
            x  = 8'($urandom);
            md = 1'($urandom_range(0, 1));
            v  = (sent < 40) && ($urandom_range(0, 9) < 8);
            step(v, x, md, $urandom_range(0, 3) != 0, acc, rdy, ov, fired, yo, mo, so);
            if (acc) begin
                sb.push_back(model(x, md));
                sent++;
            end
            if (fired) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: got y=%0d expected no output", yo);
                end else begin
                    e = sb.pop_front();
                    got++;
                    $display("[rand] y=%0d mode=%0b sat=%0b", yo, mo, so);
                    if ({yo, mo, so} !== {e.y, e.m, e.s}) begin
                        errors++;
                        $display("FAIL rand_out: got y=%0d mode=%0b sat=%0b expected y=%0d mode=%0b sat=%0b",
                                 yo, mo, so, e.y, e.m, e.s);
                    end
                end
            end
        end
        checks++;
        if (got != 40) begin
            errors++;
            $display("FAIL rand_count: got %0d expected 40", got);
        end
    endtask

    task automatic test_reset_inflight();
        logic acc, rdy, ov, fired, mo, so;
        logic [7:0] yo;
        exp_t e;
        int sent = 0, got = 0;
        sb.delete();
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 8'h20, 1'b0, 1'b1, acc, rdy, ov, fired, yo, mo, so);
        end
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL inflight_pre_valid: got %0b expected 1", out_valid);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, y_out, mode_out, sat_out} !== 11'd0) begin
            errors++;
            $display("FAIL inflight_async_clear: got valid=%0b y=%0d expected valid=0 y=0",
                     out_valid, y_out);
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 20 && got < 1; c++) begin
            step(sent < 1, 8'hE0, 1'b0, 1'b1, acc, rdy, ov, fired, yo, mo, so);
            if (acc) begin
                sb.push_back(exp_t'{y: 8'd69, m: 1'b0, s: 1'b0});
                sent++;
            end
            if (fired) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL inflight_stale: got y=%0d expected no output", yo);
                end else begin
                    e = sb.pop_front();
                    got++;
                    $display("[reset] y=%0d mode=%0b sat=%0b", yo, mo, so);
                    if ({yo, mo, so} !== {e.y, e.m, e.s}) begin
                        errors++;
                        $display("FAIL inflight_first: got y=%0d expected y=%0d", yo, e.y);
                    end
                end
            end
        end
        checks++;
        if (got != 1) begin
            errors++;
            $display("FAIL inflight_count: got %0d expected 1", got);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sigmoid();
        test_tanh();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
